// File: rtl/ysyx_220053_lsu.sv
// Load/store unit: valid/ready front end to an XLEN-aligned data bus with byte masks,
// load extension, and two-beat splitting of accesses that cross an XLEN boundary.
module ysyx_220053_lsu #(
    parameter int XLEN           = 64,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_op,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int SHW   = OFFW + 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t            state_r;
    logic              wen_r;
    logic [2:0]        op_r;
    logic [OFFW-1:0]   off_r;
    logic [XLEN-1:0]   base_r;
    logic              cross_r;
    logic [BYTES-1:0]  mask1_r;
    logic [XLEN-1:0]   wdata1_r;
    logic [XLEN-1:0]   rdata0_r;

    logic [OFFW-1:0]   off_s;
    logic [2*BYTES-1:0] lanes_s;
    logic [2*XLEN-1:0] wide_s;
    logic              cross_s;
    logic              illegal_s;
    logic [SHW-1:0]    sh0_s;
    logic [SHW-1:0]    sh1_s;

    function automatic logic [BYTES-1:0] lane_mask(input logic [1:0] sz);
        logic [BYTES-1:0] m;
        m = '0;
        case (sz)
            2'b01:   m[0]   = 1'b1;
            2'b10:   m[1:0] = 2'b11;
            2'b00:   m[3:0] = 4'hF;
            2'b11:   m      = '1;
            default: m      = '0;
        endcase
        return m;
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        logic bad;
        case (op)
            3'b111:         bad = 1'b1;
            3'b011, 3'b100: bad = (XLEN == 32);
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Truncate to the access size, then sign- or zero-extend; full-width accesses pass through.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] data, input logic [2:0] op);
        logic [XLEN-1:0] keep;
        logic            sgn;
        keep = '0;
        sgn  = 1'b0;
        case (op[1:0])
            2'b01:   begin keep[7:0]  = 8'hFF;         sgn = data[7];  end
            2'b10:   begin keep[15:0] = 16'hFFFF;      sgn = data[15]; end
            2'b00:   begin keep[31:0] = 32'hFFFF_FFFF; sgn = data[31]; end
            2'b11:   begin keep       = '1;            sgn = 1'b0;     end
            default: begin keep       = '0;            sgn = 1'b0;     end
        endcase
        if (!op[2] && sgn) begin
            return data | ~keep;
        end else begin
            return data & keep;
        end
    endfunction

    // Lane placement of the incoming request; upper halves spill into the second beat.
    always_comb begin
        off_s     = req_addr[OFFW-1:0];
        lanes_s   = {{BYTES{1'b0}}, lane_mask(req_op[1:0])} << off_s;
        wide_s    = {{XLEN{1'b0}}, req_wdata} << {off_s, 3'b000};
        cross_s   = |lanes_s[2*BYTES-1:BYTES];
        illegal_s = op_illegal(req_op);
        sh0_s     = {1'b0, off_r, 3'b000};
        sh1_s     = SHW'(XLEN) - sh0_s;
    end

    // Request/response sequencer with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            wen_r         <= 1'b0;
            op_r          <= 3'b000;
            off_r         <= '0;
            base_r        <= '0;
            cross_r       <= 1'b0;
            mask1_r       <= '0;
            wdata1_r      <= '0;
            rdata0_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        wen_r     <= req_wen;
                        op_r      <= req_op;
                        off_r     <= off_s;
                        base_r    <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        cross_r   <= cross_s;
                        mask1_r   <= req_wen ? lanes_s[2*BYTES-1:BYTES] : '0;
                        wdata1_r  <= req_wen ? wide_s[2*XLEN-1:XLEN] : '0;
                        rdata0_r  <= '0;
                        if (illegal_s || (cross_s && !MISALIGN_SPLIT)) begin
                            state_r    <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state_r       <= REQ0;
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= req_wen;
                            mem_req_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                            mem_req_wmask <= req_wen ? lanes_s[BYTES-1:0] : '0;
                            mem_req_wdata <= req_wen ? wide_s[XLEN-1:0] : '0;
                        end
                    end
                end
                REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_r       <= WAIT0;
                    end
                end
                WAIT0: begin
                    if (mem_resp_valid) begin
                        rdata0_r <= mem_resp_rdata >> sh0_s;
                        if (cross_r) begin
                            state_r       <= REQ1;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= base_r + XLEN'(BYTES);
                            mem_req_wmask <= mask1_r;
                            mem_req_wdata <= wdata1_r;
                        end else begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= wen_r ? '0 : load_ext(mem_resp_rdata >> sh0_s, op_r);
                        end
                    end
                end
                REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_r       <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (mem_resp_valid) begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= wen_r ? '0 : load_ext(rdata0_r | (mem_resp_rdata << sh1_s), op_r);
                    end
                end
                RESP, ERR: begin
                    if (resp_ready) begin
                        state_r    <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// Directed bench for ysyx_220053_lsu: a split-enabled instance driven through a zero-wait
// (optionally stalled) bus model, plus a split-disabled instance for misalignment rejection.
module tb_ysyx_220053_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_b, req_wen, resp_ready;
    logic [2:0]  req_op;
    logic [63:0] req_addr, req_wdata;
    logic        mem_req_ready, mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    logic        req_ready, resp_valid, resp_err, mem_req_valid, mem_req_wen;
    logic [63:0] resp_rdata, mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        req_ready_b, resp_valid_b, resp_err_b, mem_req_valid_b, mem_req_wen_b;
    logic [63:0] resp_rdata_b, mem_req_addr_b, mem_req_wdata_b;
    logic [7:0]  mem_req_wmask_b;

    int checks = 0;
    int failures = 0;

    int          o_lat, o_beats, o_unstable, o_extra;
    logic [63:0] o_baddr [2];
    logic [7:0]  o_bmask [2];
    logic [63:0] o_bdata [2];
    logic        o_bwen [2];
    logic [63:0] o_rdata;
    logic        o_err, o_hs_ready, o_after_valid, o_after_ready;

    ysyx_220053_lsu #(.XLEN(64), .MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    ysyx_220053_lsu #(.XLEN(64), .MISALIGN_SPLIT(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wen(req_wen), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen_b),
        .mem_req_addr(mem_req_addr_b), .mem_req_wdata(mem_req_wdata_b), .mem_req_wmask(mem_req_wmask_b),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    // Issue one request, serve its bus beats (rd0/rd1 returned one cycle after acceptance),
    // and record latency, beats, response and stability observations in o_* for the caller.
    task automatic drive(input logic wen, input logic [2:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rd0, input logic [63:0] rd1,
                         input int rdy_delay, input int rsp_delay);
        logic        pending;
        logic [63:0] pend_data, s_addr, s_data;
        logic [7:0]  s_mask;
        int          stall;
        pending = 1'b0; pend_data = 64'h0; stall = 0;
        s_addr = 64'h0; s_data = 64'h0; s_mask = 8'h0;
        o_beats = 0; o_unstable = 0; o_extra = 0;
        for (int i = 0; i < 2; i++) begin
            o_baddr[i] = 64'h0; o_bmask[i] = 8'h0; o_bdata[i] = 64'h0; o_bwen[i] = 1'b0;
        end
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_wen = 1'b0; req_op = 3'b000; req_addr = 64'h0; req_wdata = 64'h0;
        o_lat = 1;
        while (o_lat < 40) begin
            mem_resp_valid = pending; mem_resp_rdata = pend_data; pending = 1'b0;
            if (resp_valid) break;
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (stall == 0) begin
                    s_addr = mem_req_addr; s_mask = mem_req_wmask; s_data = mem_req_wdata;
                end else if (mem_req_addr !== s_addr || mem_req_wmask !== s_mask || mem_req_wdata !== s_data) begin
                    o_unstable++;
                end
                if (stall >= rdy_delay) begin
                    mem_req_ready = 1'b1;
                    if (o_beats < 2) begin
                        o_baddr[o_beats] = mem_req_addr; o_bmask[o_beats] = mem_req_wmask;
                        o_bdata[o_beats] = mem_req_wdata; o_bwen[o_beats] = mem_req_wen;
                    end
                    pending = 1'b1;
                    pend_data = (o_beats == 0) ? rd0 : rd1;
                    o_beats++;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
            @(negedge clk);
            o_lat++;
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        o_rdata = resp_rdata; o_err = resp_err;
        for (int k = 0; k < rsp_delay; k++) begin
            if (resp_valid !== 1'b1 || resp_rdata !== o_rdata || resp_err !== o_err) o_unstable++;
            @(negedge clk);
        end
        resp_ready = 1'b1;
        o_hs_ready = req_ready;
        @(negedge clk);
        resp_ready = 1'b0;
        o_after_valid = resp_valid;
        o_after_ready = req_ready;
        for (int k = 0; k < 2; k++) begin
            if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) o_extra++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        checks++; if ({resp_valid, resp_err, mem_req_valid, mem_req_wen} !== 4'b0000) begin failures++;
            $display("FAIL rst_flags got=%b exp=0000", {resp_valid, resp_err, mem_req_valid, mem_req_wen}); end
        checks++; if ({resp_rdata, mem_req_addr, mem_req_wdata, mem_req_wmask} !== 200'h0) begin failures++;
            $display("FAIL rst_data got=%h/%h/%h/%h exp=0", resp_rdata, mem_req_addr, mem_req_wdata, mem_req_wmask); end
        checks++; if (req_ready_b !== 1'b1) begin failures++; $display("FAIL rst_req_ready_b got=%b exp=1", req_ready_b); end
    endtask

    task automatic test_aligned_store();
        drive(1'b1, 3'b011, 64'h8000_0000, 64'h1122_3344_5566_7788, 64'h0, 64'h0, 0, 0);
        checks++; if (o_lat !== 3) begin failures++; $display("FAIL sd_latency got=%0d exp=3", o_lat); end
        checks++; if (o_beats !== 1) begin failures++; $display("FAIL sd_beats got=%0d exp=1", o_beats); end
        checks++; if (o_baddr[0] !== 64'h8000_0000 || o_bmask[0] !== 8'hFF || o_bwen[0] !== 1'b1) begin failures++;
            $display("FAIL sd_beat0 got=%h/%h/%b exp=80000000/ff/1", o_baddr[0], o_bmask[0], o_bwen[0]); end
        checks++; if (o_bdata[0] !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL sd_wdata got=%h exp=1122334455667788", o_bdata[0]); end
        checks++; if (o_err !== 1'b0 || o_rdata !== 64'h0) begin failures++; $display("FAIL sd_resp got=%b/%h exp=0/0", o_err, o_rdata); end
        checks++; if (o_hs_ready !== 1'b0 || o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin failures++;
            $display("FAIL sd_handshake got=%b%b%b exp=001", o_hs_ready, o_after_valid, o_after_ready); end
    endtask

    task automatic test_byte_loads();
        drive(1'b0, 3'b001, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 64'h0, 0, 0);
        checks++; if (o_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", o_rdata); end
        checks++; if (o_lat !== 3 || o_beats !== 1) begin failures++; $display("FAIL lb_timing got=%0d/%0d exp=3/1", o_lat, o_beats); end
        checks++; if (o_baddr[0] !== 64'h8000_0000 || o_bmask[0] !== 8'h00 || o_bwen[0] !== 1'b0) begin failures++;
            $display("FAIL lb_beat0 got=%h/%h/%b exp=80000000/00/0", o_baddr[0], o_bmask[0], o_bwen[0]); end
        drive(1'b0, 3'b101, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 64'h0, 0, 0);
        checks++; if (o_rdata !== 64'h0000_0000_0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=0000000000000080", o_rdata); end
        drive(1'b0, 3'b000, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 64'h0, 0, 0);
        checks++; if (o_rdata !== 64'hFFFF_FFFF_8765_4321) begin failures++; $display("FAIL lw_data got=%h exp=ffffffff87654321", o_rdata); end
    endtask

    task automatic test_split_store();
        drive(1'b1, 3'b000, 64'h8000_0006, 64'hAABB_CCDD, 64'h0, 64'h0, 0, 0);
        checks++; if (o_lat !== 5 || o_beats !== 2) begin failures++; $display("FAIL sw_split_timing got=%0d/%0d exp=5/2", o_lat, o_beats); end
        checks++; if (o_baddr[0] !== 64'h8000_0000 || o_bmask[0] !== 8'hC0 || o_bdata[0] !== 64'hCCDD_0000_0000_0000) begin failures++;
            $display("FAIL sw_split_beat0 got=%h/%h/%h exp=80000000/c0/ccdd000000000000", o_baddr[0], o_bmask[0], o_bdata[0]); end
        checks++; if (o_baddr[1] !== 64'h8000_0008 || o_bmask[1] !== 8'h03 || o_bdata[1] !== 64'h0000_0000_0000_AABB || o_bwen[1] !== 1'b1) begin failures++;
            $display("FAIL sw_split_beat1 got=%h/%h/%h/%b exp=80000008/03/000000000000aabb/1", o_baddr[1], o_bmask[1], o_bdata[1], o_bwen[1]); end
        checks++; if (o_err !== 1'b0 || o_rdata !== 64'h0) begin failures++; $display("FAIL sw_split_resp got=%b/%h exp=0/0", o_err, o_rdata); end
    endtask

    task automatic test_split_load();
        drive(1'b0, 3'b010, 64'h8000_000F, 64'h0, 64'h34AA_BBCC_DDEE_FF11, 64'h5566_7788_99AA_BB92, 0, 0);
        checks++; if (o_rdata !== 64'hFFFF_FFFF_FFFF_9234) begin failures++; $display("FAIL lh_split_data got=%h exp=ffffffffffff9234", o_rdata); end
        checks++; if (o_lat !== 5 || o_baddr[0] !== 64'h8000_0008 || o_baddr[1] !== 64'h8000_0010) begin failures++;
            $display("FAIL lh_split_beats got=%0d/%h/%h exp=5/80000008/80000010", o_lat, o_baddr[0], o_baddr[1]); end
        drive(1'b0, 3'b110, 64'h8000_000F, 64'h0, 64'h34AA_BBCC_DDEE_FF11, 64'h5566_7788_99AA_BB92, 0, 0);
        checks++; if (o_rdata !== 64'h0000_0000_0000_9234) begin failures++; $display("FAIL lhu_split_data got=%h exp=0000000000009234", o_rdata); end
    endtask

    task automatic test_errors();
        drive(1'b1, 3'b111, 64'h8000_0000, 64'h55, 64'h0, 64'h0, 0, 0);
        checks++; if (o_lat !== 1 || o_beats !== 0) begin failures++; $display("FAIL illegal_timing got=%0d/%0d exp=1/0", o_lat, o_beats); end
        checks++; if (o_err !== 1'b1 || o_rdata !== 64'h0) begin failures++; $display("FAIL illegal_resp got=%b/%h exp=1/0", o_err, o_rdata); end
        checks++; if (o_after_ready !== 1'b1 || o_extra !== 0) begin failures++; $display("FAIL illegal_after got=%b/%0d exp=1/0", o_after_ready, o_extra); end
        @(negedge clk);
        req_valid_b = 1'b1; req_wen = 1'b0; req_op = 3'b000; req_addr = 64'h8000_0005;
        @(negedge clk);
        req_valid_b = 1'b0; req_addr = 64'h0;
        checks++; if (resp_valid_b !== 1'b1 || resp_err_b !== 1'b1 || resp_rdata_b !== 64'h0) begin failures++;
            $display("FAIL nosplit_resp got=%b/%b/%h exp=1/1/0", resp_valid_b, resp_err_b, resp_rdata_b); end
        checks++; if (mem_req_valid_b !== 1'b0 || req_ready_b !== 1'b0) begin failures++;
            $display("FAIL nosplit_bus got=%b/%b exp=0/0", mem_req_valid_b, req_ready_b); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (resp_valid_b !== 1'b0 || req_ready_b !== 1'b1 || mem_req_valid_b !== 1'b0) begin failures++;
            $display("FAIL nosplit_done got=%b/%b/%b exp=0/1/0", resp_valid_b, req_ready_b, mem_req_valid_b); end
    endtask

    task automatic test_wrap();
        drive(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00, 0, 0);
        checks++; if (o_beats !== 2 || o_baddr[0] !== 64'hFFFF_FFFF_FFFF_FFF8 || o_baddr[1] !== 64'h0) begin failures++;
            $display("FAIL wrap_beats got=%0d/%h/%h exp=2/fffffffffffffff8/0", o_beats, o_baddr[0], o_baddr[1]); end
        checks++; if (o_rdata !== 64'hDDEE_FF00_1122_3344 || o_lat !== 5) begin failures++;
            $display("FAIL wrap_data got=%h/%0d exp=ddeeff0011223344/5", o_rdata, o_lat); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 3'b000, 64'h8000_0010, 64'hDEAD_BEEF, 64'h0, 64'h0, 4, 3);
        checks++; if (o_lat !== 7 || o_beats !== 1) begin failures++; $display("FAIL bp_store_timing got=%0d/%0d exp=7/1", o_lat, o_beats); end
        checks++; if (o_bmask[0] !== 8'h0F || o_bdata[0] !== 64'h0000_0000_DEAD_BEEF) begin failures++;
            $display("FAIL bp_store_beat got=%h/%h exp=0f/00000000deadbeef", o_bmask[0], o_bdata[0]); end
        checks++; if (o_unstable !== 0 || o_extra !== 0) begin failures++; $display("FAIL bp_store_stable got=%0d/%0d exp=0/0", o_unstable, o_extra); end
        checks++; if (o_hs_ready !== 1'b0 || o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin failures++;
            $display("FAIL bp_store_handshake got=%b%b%b exp=001", o_hs_ready, o_after_valid, o_after_ready); end
        drive(1'b0, 3'b110, 64'h8000_000F, 64'h0, 64'h34AA_BBCC_DDEE_FF11, 64'h5566_7788_99AA_BB92, 4, 3);
        checks++; if (o_lat !== 13 || o_rdata !== 64'h9234) begin failures++; $display("FAIL bp_load got=%0d/%h exp=13/9234", o_lat, o_rdata); end
        checks++; if (o_unstable !== 0 || o_extra !== 0) begin failures++; $display("FAIL bp_load_stable got=%0d/%0d exp=0/0", o_unstable, o_extra); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_op = 3'b000; req_addr = 64'h8000_0000;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 64'h0; mem_req_ready = 1'b1;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL rstw_req got=%b exp=1", mem_req_valid); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || {resp_valid, resp_err, mem_req_valid} !== 3'b000 || mem_req_addr !== 64'h0) begin failures++;
            $display("FAIL rstw_outputs got=%b/%b/%h exp=1/000/0", req_ready, {resp_valid, resp_err, mem_req_valid}, mem_req_addr); end
        rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234_5678;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 64'h0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin failures++;
            $display("FAIL rstw_late_resp got=%b/%h/%b/%b exp=0/0/0/1", resp_valid, resp_rdata, mem_req_valid, req_ready); end
        drive(1'b0, 3'b101, 64'h8000_0001, 64'h0, 64'h0000_0000_0000_C300, 64'h0, 0, 0);
        checks++; if (o_rdata !== 64'hC3 || o_lat !== 3) begin failures++; $display("FAIL rstw_recover got=%h/%0d exp=c3/3", o_rdata, o_lat); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0; req_wen = 1'b0; req_op = 3'b000;
        req_addr = 64'h0; req_wdata = 64'h0; resp_ready = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;
        test_reset();
        test_aligned_store();
        test_byte_loads();
        test_split_store();
        test_split_load();
        test_errors();
        test_wrap();
        test_backpressure();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
